alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Command-side driver for the combinational 32-bit ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's a/b/alu_ctrl inputs from registers. It then captures the ALU's result and zero outputs and returns them over a valid/ready response channel. It keeps a running accumulator that commands can select as operand a, which allows multi-step operation chains.

Parameters:
WIDTH, 32, datapath width of operands, result and accumulator
OP_W, 4, width of the opcode and alu_ctrl
MAX_OP, 7, highest legal opcode; codes above it are illegal
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  OP_W  ALU opcode (0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 INC a, 7 DEC a)
cmd_use_acc  in  1  1: operand a = accumulator; 0: operand a = cmd_a
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
alu_a  out  WIDTH  registered operand to ALU a
alu_b  out  WIDTH  registered operand to ALU b
alu_ctrl  out  OP_W  registered opcode to ALU
alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl)
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  captured zero flag
rsp_err  out  1  illegal opcode flag
acc  out  WIDTH  accumulator value
op_count  out  CNT_W  legal operations completed, saturating

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE. All other outputs 0: cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, acc, op_count.
- FSM has three states: IDLE, EXEC, RESP.
- cmd_ready = 1 only in IDLE. It is a registered/state-decoded output and never depends combinationally on cmd_valid.
- IDLE:
  - On cmd_valid && cmd_ready at edge N, register alu_ctrl = cmd_op and alu_b = cmd_b.
  - Register alu_a = acc if cmd_use_acc, else cmd_a. acc is sampled at edge N.
  - Go to EXEC.
- EXEC: one settle cycle. At edge N+1:
  - Capture rsp_result = alu_result and rsp_zero = alu_zero.
  - If cmd_op > MAX_OP: rsp_result = 0, rsp_zero = 1, rsp_err = 1; acc and op_count unchanged.
  - Otherwise: rsp_err = 0, acc <= alu_result, op_count <= op_count+1 (held at all-ones once saturated).
  - Set rsp_valid; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_result, rsp_zero and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that edge: clear rsp_valid, go to IDLE; cmd_ready rises the same edge.
- Latency: command accepted at edge N → rsp_valid high after edge N+1. With rsp_ready held high, throughput is one command per 3 cycles.
- alu_a, alu_b and alu_ctrl hold their last values between commands. They are not cleared on response.
- Arithmetic: all mod 2^WIDTH; the ALU handles wrap and the sequencer performs no extension.
- Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready stays 0 and no new command is accepted.
- Commands presented while cmd_ready = 0 are ignored. The source must hold them valid per the handshake.
- Reset asserted in any state: all outputs return immediately to reset values. An in-flight response is dropped and the accumulator is cleared.

Test Plan:
- ADD: cmd_op=4, a=5, b=7, use_acc=0 → one cycle later alu_ctrl=4, alu_a=5, alu_b=7. Next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_err=0, acc=12, op_count=1.
- SUB to zero, then DEC wrap: SUB 9−9 → rsp_result=0, rsp_zero=1. Then DEC with use_acc=1 → rsp_result=0xFFFFFFFF, rsp_zero=0, acc=0xFFFFFFFF.
- Accumulator chain: ADD 0x10+0x20, then INC with use_acc=1, then XOR with use_acc=1, b=0x31 → results 0x30, 0x31, 0x0; final rsp_zero=1; op_count=3.
- Illegal opcode: cmd_op=4'b1010, acc=0x55 → rsp_err=1, rsp_result=0, rsp_zero=1, acc stays 0x55, op_count unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while cmd_valid=1 with a new command → rsp_* stable, cmd_ready=0. The second command is accepted only on the cycle after rsp_ready=1.
- Reset mid-operation: assert rst_n=0 during EXEC → rsp_valid, acc, alu_* and op_count read 0 within the same cycle. After release, cmd_ready=1 in the first cycle.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between an operation source and the ALU sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic             cmd_use_acc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from registered operands, returns result/zero over a
// response handshake and keeps a running accumulator usable as operand a.
module alu_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int OP_W   = 4,
    parameter int MAX_OP = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic [WIDTH-1:0]  acc,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OP_W-1:0] MAX_OP_C = OP_W'(MAX_OP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic             cmd_fire;
    logic             illegal_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Gated by rst_n so the handshake reads 0 while held in reset, 1 as soon as released.
    assign bus.cmd_ready  = rst_n && (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;

    assign cmd_fire   = (state == IDLE) && bus.cmd_valid;
    assign illegal_op = (alu_ctrl > MAX_OP_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers: loaded on accept, held afterwards until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
        end else if (cmd_fire) begin
            alu_a    <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_b    <= bus.cmd_b;
            alu_ctrl <= bus.cmd_op;
        end
    end

    // Result capture after the ALU has settled for one cycle; illegal codes leave state alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_r <= '0;
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            acc          <= '0;
            op_count     <= '0;
        end else if (state == EXEC) begin
            if (illegal_op) begin
                rsp_result_r <= '0;
                rsp_zero_r   <= 1'b1;
                rsp_err_r    <= 1'b1;
            end else begin
                rsp_result_r <= alu_result;
                rsp_zero_r   <= alu_zero;
                rsp_err_r    <= 1'b0;
                acc          <= alu_result;
                op_count     <= sat_inc(op_count);
            end
        end
    end

endmodule
